// File: rtl/psram_pkg.sv
`default_nettype none
// =============================================================================
// Module   : psram_pkg
// Brief    : Shared state encodings, port selectors and 50 MHz timing defaults
//            for the asynchronous-mode CellularRAM arbiter.
// Revision : 1.0 - initial release
// =============================================================================
package psram_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ACCESS  = 2'd1;
    localparam state_t RECOVER = 2'd2;

    localparam logic PORT_VID  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    // 4 x 20 ns = 80 ns strobe width covers the 70 ns part at 50 MHz
    localparam int DEF_ADDR_W      = 23;
    localparam int DEF_ACCESS_CYC  = 4;
    localparam int DEF_RECOVER_CYC = 1;

endpackage
`default_nettype wire

// File: rtl/psram_arb2.sv
`default_nettype none
// =============================================================================
// Module   : psram_arb2
// Brief    : Two-port grant select (video / host). Fixed video priority, or
//            round-robin when PSRAM_RR_ARB_EN is defined.
// Revision : 1.0 - initial release
// =============================================================================
module psram_arb2
    import psram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_vidReq,
    input  logic i_hostReq,
    input  logic i_take,
    output logic o_grant
);

`ifdef PSRAM_RR_ARB_EN
    logic r_ptr;

    // r_ptr names the port that wins a tie; a lone requester always wins
    always_comb begin
        o_grant = PORT_VID;
        if (i_vidReq && i_hostReq) begin
            o_grant = r_ptr;
        end else if (i_hostReq) begin
            o_grant = PORT_HOST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= PORT_VID;
        end else if (i_take) begin
            r_ptr <= ~o_grant;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_take};
    assign o_grant  = (i_hostReq && !i_vidReq) ? PORT_HOST : PORT_VID;
`endif

endmodule
`default_nettype wire

// File: rtl/psram_async_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : psram_async_arbiter
// Brief    : Sequences asynchronous CellularRAM accesses for the video fetch
//            and host ports. Optional round-robin via PSRAM_RR_ARB_EN.
// Revision : 1.0 - initial release
// =============================================================================
module psram_async_arbiter
    import psram_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int ACCESS_CYC  = DEF_ACCESS_CYC,
    parameter int RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_done,
    output logic [15:0]       vid_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    input  logic [1:0]        host_be,
    output logic              host_done,
    output logic [15:0]       host_rdata,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [15:0]       mem_db_o,
    output logic              mem_db_t,
    input  logic [15:0]       mem_db_i,
    output logic              mem_cs_n,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    output logic              mem_lb_n,
    output logic              mem_ub_n,
    output logic              mem_adv_n,
    output logic              mem_clk,
    output logic              mem_cre
);

    localparam int c_cntMax = (ACCESS_CYC > RECOVER_CYC) ? ACCESS_CYC : RECOVER_CYC;
    localparam int c_cntW   = (c_cntMax > 1) ? $clog2(c_cntMax) : 1;
    localparam logic [c_cntW-1:0] c_accLast = c_cntW'(ACCESS_CYC - 1);
    localparam logic [c_cntW-1:0] c_recLast = c_cntW'(RECOVER_CYC - 1);

    state_t              r_state;
    logic [c_cntW-1:0]   r_cnt;
    logic                r_port;
    logic                r_we;

    logic                w_anyReq;
    logic                w_take;
    logic                w_grant;
    logic                w_reqWe;
    logic [ADDR_W-1:0]   w_reqAddr;

    assign mem_adv_n = 1'b0;
    assign mem_clk   = 1'b0;
    assign mem_cre   = 1'b0;

    assign w_anyReq  = vid_req | host_req;
    assign w_take    = (r_state == IDLE) && w_anyReq;
    assign w_reqWe   = (w_grant == PORT_HOST) ? host_we : 1'b0;
    assign w_reqAddr = (w_grant == PORT_HOST) ? host_addr : vid_addr;

    psram_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_vidReq  (vid_req),
        .i_hostReq (host_req),
        .i_take    (w_take),
        .o_grant   (w_grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_port     <= PORT_VID;
            r_we       <= 1'b0;
            mem_adr    <= '0;
            mem_db_o   <= '0;
            mem_db_t   <= 1'b1;
            mem_cs_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_lb_n   <= 1'b1;
            mem_ub_n   <= 1'b1;
            vid_done   <= 1'b0;
            vid_rdata  <= '0;
            host_done  <= 1'b0;
            host_rdata <= '0;
        end else begin
            vid_done  <= 1'b0;
            host_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Strobes are registered here so they assert in the first ACCESS cycle
                    if (w_anyReq) begin
                        r_state  <= ACCESS;
                        r_cnt    <= '0;
                        r_port   <= w_grant;
                        r_we     <= w_reqWe;
                        mem_adr  <= w_reqAddr;
                        mem_cs_n <= 1'b0;
                        mem_oe_n <= w_reqWe;
                        mem_we_n <= ~w_reqWe;
                        mem_db_t <= ~w_reqWe;
                        mem_lb_n <= w_reqWe & ~host_be[0];
                        mem_ub_n <= w_reqWe & ~host_be[1];
                        if (w_reqWe) begin
                            mem_db_o <= host_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (r_cnt == c_accLast) begin
                        r_state  <= RECOVER;
                        r_cnt    <= '0;
                        mem_cs_n <= 1'b1;
                        mem_oe_n <= 1'b1;
                        mem_we_n <= 1'b1;
                        mem_lb_n <= 1'b1;
                        mem_ub_n <= 1'b1;
                        if (r_port == PORT_VID) begin
                            vid_done <= 1'b1;
                            if (!r_we) begin
                                vid_rdata <= mem_db_i;
                            end
                        end else begin
                            host_done <= 1'b1;
                            if (!r_we) begin
                                host_rdata <= mem_db_i;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RECOVER: begin
                    // Write data stays driven through recovery for hold time
                    if (r_cnt == c_recLast) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        mem_db_t <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    mem_db_t <= 1'b1;
                    mem_cs_n <= 1'b1;
                    mem_oe_n <= 1'b1;
                    mem_we_n <= 1'b1;
                    mem_lb_n <= 1'b1;
                    mem_ub_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psram_async_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_psram_async_arbiter
// Brief    : Self-checking bench for psram_async_arbiter (default timing plus a
//            2/2 timing instance). Honours PSRAM_RR_ARB_EN when defined.
// Revision : 1.0 - initial release
// =============================================================================
module tb_psram_async_arbiter;

`ifdef PSRAM_RR_ARB_EN
    localparam bit c_rr = 1'b1;
`else
    localparam bit c_rr = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: default timing (4/1)
    logic        vid_req, host_req, host_we;
    logic [22:0] vid_addr, host_addr;
    logic [15:0] host_wdata;
    logic [1:0]  host_be;
    logic        vid_done, host_done;
    logic [15:0] vid_rdata, host_rdata;
    logic [22:0] mem_adr;
    logic [15:0] mem_db_o, mem_db_i;
    logic        mem_db_t, mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n;
    logic        mem_adv_n, memClk, mem_cre;

    psram_async_arbiter dutA (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_done(vid_done), .vid_rdata(vid_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_be(host_be), .host_done(host_done), .host_rdata(host_rdata),
        .mem_adr(mem_adr), .mem_db_o(mem_db_o), .mem_db_t(mem_db_t), .mem_db_i(mem_db_i),
        .mem_cs_n(mem_cs_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
        .mem_lb_n(mem_lb_n), .mem_ub_n(mem_ub_n),
        .mem_adv_n(mem_adv_n), .mem_clk(memClk), .mem_cre(mem_cre)
    );

    // Instance B: ACCESS_CYC = 2, RECOVER_CYC = 2, video port only
    logic        bVidReq;
    logic [22:0] bVidAddr;
    logic        bHostReq = 1'b0, bHostWe = 1'b0;
    logic [22:0] bHostAddr = '0;
    logic [15:0] bHostWdata = '0;
    logic [1:0]  bHostBe = '0;
    logic        bVidDone, bHostDone;
    logic [15:0] bVidRdata, bHostRdata;
    logic [22:0] bMemAdr;
    logic [15:0] bMemDbO, bMemDbI;
    logic        bDbT, bCsN, bOeN, bWeN, bLbN, bUbN, bAdvN, bMemClk, bCre;

    psram_async_arbiter #(.ADDR_W(23), .ACCESS_CYC(2), .RECOVER_CYC(2)) dutB (
        .clk(clk), .rst(rst),
        .vid_req(bVidReq), .vid_addr(bVidAddr), .vid_done(bVidDone), .vid_rdata(bVidRdata),
        .host_req(bHostReq), .host_we(bHostWe), .host_addr(bHostAddr), .host_wdata(bHostWdata),
        .host_be(bHostBe), .host_done(bHostDone), .host_rdata(bHostRdata),
        .mem_adr(bMemAdr), .mem_db_o(bMemDbO), .mem_db_t(bDbT), .mem_db_i(bMemDbI),
        .mem_cs_n(bCsN), .mem_oe_n(bOeN), .mem_we_n(bWeN),
        .mem_lb_n(bLbN), .mem_ub_n(bUbN),
        .mem_adv_n(bAdvN), .mem_clk(bMemClk), .mem_cre(bCre)
    );

    // Small PSRAM model for A: 16 words, aliased on adr[3:0]
    logic [15:0] memArr [16];
    assign mem_db_i = (!mem_cs_n && !mem_oe_n) ? memArr[mem_adr[3:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) memArr[i] <= 16'h1000 + 16'(i);
            memArr[3] <= 16'hBEEF;
        end else if (!mem_cs_n && !mem_we_n) begin
            if (!mem_lb_n) memArr[mem_adr[3:0]][7:0]  <= mem_db_o[7:0];
            if (!mem_ub_n) memArr[mem_adr[3:0]][15:8] <= mem_db_o[15:8];
        end
    end
    assign bMemDbI = (!bCsN && !bOeN) ? (16'hB000 | {5'b0, bMemAdr[10:0]}) : 16'hDEAD;

    int errors = 0;
    int checks = 0;
    logic [15:0] vidQ [$];
    logic [16:0] hostQ [$];
    logic [16:0] hEntry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] strb();
        return {mem_cs_n, mem_oe_n, mem_we_n, mem_lb_n, mem_ub_n, mem_db_t};
    endfunction

    // Scoreboard pop and bus-contention watch on both instances
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0) begin
            checks++;
            assert (!(mem_oe_n === 1'b0 && mem_db_t === 1'b0) && !(bOeN === 1'b0 && bDbT === 1'b0)) else begin
                errors++;
                $error("FAIL bus_contention: A oe_n=%b db_t=%b B oe_n=%b db_t=%b, required never both 0",
                       mem_oe_n, mem_db_t, bOeN, bDbT);
            end
            if (vid_done === 1'b1) begin
                if (vidQ.size() == 0) chk("vid_done_spurious", 32'(vid_done), 32'd0);
                else chk("vid_rdata", 32'(vid_rdata), 32'(vidQ.pop_front()));
            end
            if (host_done === 1'b1) begin
                if (hostQ.size() == 0) chk("host_done_spurious", 32'(host_done), 32'd0);
                else begin
                    hEntry = hostQ.pop_front();
                    if (hEntry[16]) chk("host_rdata", 32'(host_rdata), 32'(hEntry[15:0]));
                end
            end
        end
    end

    // Instance B: access length and recovery gap between back-to-back accesses
    int bLow = 0, bHigh = 0;
    bit bSeen = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst !== 1'b0) begin
            bLow = 0; bHigh = 0; bSeen = 1'b0;
        end else if (bCsN === 1'b0) begin
            // 2 recovery cycles plus the IDLE sampling cycle
            if (bLow == 0 && bSeen) chk("b_recover_gap", 32'(bHigh), 32'd3);
            bLow++; bHigh = 0;
        end else begin
            if (bLow != 0) begin
                chk("b_access_len", 32'(bLow), 32'd2);
                bSeen = 1'b1;
            end
            bLow = 0; bHigh++;
        end
    end

    task automatic doAccess(input string tag, input bit isHost, input bit we,
                            input logic [22:0] addr, input logic [15:0] wd, input logic [1:0] be);
        logic [5:0] expS;
        bit seen;
        int lat;
        expS = we ? {1'b0, 1'b1, 1'b0, ~be[0], ~be[1], 1'b0} : 6'b001001;
        if (isHost) begin
            host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd; host_be = be;
            hostQ.push_back({~we, memArr[addr[3:0]]});
        end else begin
            vid_req = 1'b1; vid_addr = addr;
            vidQ.push_back(memArr[addr[3:0]]);
        end
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            if (i == 1) chk({tag, "_strobes"}, 32'(strb()), 32'(expS));
            if ((isHost ? host_done : vid_done) === 1'b1) begin
                seen = 1'b1; lat = i;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'd5);
        vid_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic runPair(input string tag, input bit expHostFirst,
                           input logic [22:0] va, input logic [22:0] ha, input logic [15:0] hd);
        int starts [2];
        bit isWr [2];
        int n, t;
        logic prevCs;
        bit vSeen, hSeen;
        vid_req = 1'b1; vid_addr = va;
        host_req = 1'b1; host_we = 1'b1; host_addr = ha; host_wdata = hd; host_be = 2'b11;
        vidQ.push_back(memArr[va[3:0]]);
        hostQ.push_back({1'b0, 16'h0000});
        starts[0] = -100; starts[1] = 100; isWr[0] = 1'b0; isWr[1] = 1'b0;
        n = 0; t = 0; prevCs = 1'b1; vSeen = 1'b0; hSeen = 1'b0;
        for (int i = 0; i < 30 && !(vSeen && hSeen); i++) begin
            @(negedge clk);
            t++;
            if (mem_cs_n === 1'b0 && prevCs === 1'b1 && n < 2) begin
                starts[n] = t; isWr[n] = ~mem_we_n; n++;
            end
            prevCs = mem_cs_n;
            if (vid_done === 1'b1) begin vid_req = 1'b0; vSeen = 1'b1; end
            if (host_done === 1'b1) begin host_req = 1'b0; hSeen = 1'b1; end
        end
        chk({tag, "_both_done"}, 32'({vSeen, hSeen}), 32'd3);
        chk({tag, "_first_start"}, 32'(starts[0]), 32'd1);
        chk({tag, "_first_is_host"}, 32'(isWr[0]), 32'(expHostFirst));
        chk({tag, "_second_gap"}, 32'(starts[1] - starts[0]), 32'd6);
        @(negedge clk);
    endtask

    initial begin
        bit seen;
        int lastCyc;
        rst = 1'b1;
        vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_be = '0;
        bVidReq = 1'b0; bVidAddr = '0;
        repeat (3) @(negedge clk);

        chk("rst_strobes", 32'(strb()), 32'h3F);
        chk("rst_adr", 32'(mem_adr), 32'd0);
        chk("rst_db_o", 32'(mem_db_o), 32'd0);
        chk("rst_done", 32'({vid_done, host_done}), 32'd0);
        chk("rst_rdata", {vid_rdata, host_rdata}, 32'd0);
        chk("tied_async", 32'({mem_adv_n, memClk, mem_cre}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Video read of 0x000123; model returns 0xBEEF
        vid_addr = 23'h000123; vid_req = 1'b1;
        vidQ.push_back(16'hBEEF);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t1_strobes", 32'(strb()), 32'b001001);
            chk("t1_adr", 32'(mem_adr), 32'h000123);
            chk("t1_early_done", 32'(vid_done), 32'd0);
        end
        @(negedge clk);
        chk("t1_recover_strobes", 32'(strb()), 32'h3F);
        chk("t1_vid_done", 32'(vid_done), 32'd1);
        vid_req = 1'b0;
        @(negedge clk);
        chk("t1_done_once", 32'(vid_done), 32'd0);
        chk("t1_rdata_held", 32'(vid_rdata), 32'hBEEF);

        // Host upper-byte write to the top address
        host_req = 1'b1; host_we = 1'b1; host_addr = 23'h7FFFFF; host_wdata = 16'h1234; host_be = 2'b10;
        hostQ.push_back({1'b0, 16'h0000});
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_strobes", 32'(strb()), 32'b010100);
            chk("t2_db_o", 32'(mem_db_o), 32'h1234);
            chk("t2_adr", 32'(mem_adr), 32'h7FFFFF);
        end
        @(negedge clk);
        chk("t2_recover_strobes", 32'(strb()), 32'b111110);
        chk("t2_recover_db_o", 32'(mem_db_o), 32'h1234);
        chk("t2_host_done", 32'(host_done), 32'd1);
        host_req = 1'b0;
        @(negedge clk);
        chk("t2_released", 32'(strb()), 32'h3F);
        chk("t2_done_once", 32'(host_done), 32'd0);

        doAccess("rd_top", 1'b1, 1'b0, 23'h7FFFFF, 16'h0000, 2'b00);
        chk("rd_top_merge", 32'(host_rdata), 32'h120F);
        doAccess("wr_be00", 1'b1, 1'b1, 23'h000009, 16'hFFFF, 2'b00);
        doAccess("rd_be00", 1'b1, 1'b0, 23'h000009, 16'h0000, 2'b11);
        chk("rd_be00_unchanged", 32'(host_rdata), 32'h1009);

        // Simultaneous requests, then again after a lone video access
        runPair("pair1", 1'b0, 23'h000005, 23'h000006, 16'hA5A5);
        doAccess("lone_vid", 1'b0, 1'b0, 23'h000007, 16'h0000, 2'b00);
        runPair("pair2", c_rr, 23'h00000A, 23'h00000B, 16'h5A5A);

        // Reset in the 2nd ACCESS cycle of a write
        host_req = 1'b1; host_we = 1'b1; host_addr = 23'h000008; host_wdata = 16'hFFFF; host_be = 2'b11;
        @(negedge clk);
        chk("t4_acc1", 32'(strb()), 32'b010000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; host_req = 1'b0;
        chk("t4_rst_strobes", 32'(strb()), 32'h3F);
        chk("t4_rst_done", 32'(host_done), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t4_no_done", 32'(host_done), 32'd0);
        end
        doAccess("t4_after", 1'b1, 1'b0, 23'h000003, 16'h0000, 2'b00);

        // Continuous video stream on the 2/2 instance
        bVidAddr = 23'h000010; bVidReq = 1'b1;
        lastCyc = 0;
        for (int a = 0; a < 10; a++) begin
            seen = 1'b0;
            for (int i = 1; i <= 20 && !seen; i++) begin
                @(negedge clk);
                if (bVidDone === 1'b1) seen = 1'b1;
            end
            chk("t5_done_seen", 32'(seen), 32'd1);
            chk("t5_rdata", 32'(bVidRdata), 32'hB010 + 32'(a));
            if (a > 0) chk("t5_period", 32'(cyc - lastCyc), 32'd5);
            lastCyc = cyc;
            bVidAddr = 23'h000010 + 23'(a + 1);
        end
        bVidReq = 1'b0;
        repeat (6) @(negedge clk);

        chk("vidQ_drained", 32'(vidQ.size()), 32'd0);
        chk("hostQ_drained", 32'(hostQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
